// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the MISC-V multi-cycle controller: opcodes, state codes,
// datapath mux/ALU codes and the bundled control-word type.
package multicycle_ctrl_pkg;

  localparam logic [2:0] OP_R   = 3'b000;
  localparam logic [2:0] OP_I   = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_ST  = 3'b011;
  localparam logic [2:0] OP_BEQ = 3'b100;
  localparam logic [2:0] OP_BNE = 3'b101;
  localparam logic [2:0] OP_J   = 3'b110;
  localparam logic [2:0] OP_JAL = 3'b111;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_ALU_WB   = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_TWO = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       link_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // A store finishes on its memory handshake; every other final state retires unconditionally.
  function automatic logic instr_retires(input logic [3:0] st, input logic mem_ready);
    return (st == S_ALU_WB) || (st == S_MEM_WB) || (st == S_BRANCH) ||
           (st == S_JUMP) || ((st == S_MEM_WR) && mem_ready);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Single-port memory handshake between the controller (master) and memory (slave).
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/ctrl_out_decode.sv
// Combinational control-word decode: Moore outputs per state plus the few Mealy
// terms (fetch completion and branch condition).
module ctrl_out_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_TWO;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.pc_src    = PC_SEQ;
      end
      // ALU is idle here, so it precomputes PC + imm as the branch target.
      S_DECODE: ctrl.alu_src_b = SRCB_IMM;
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNC;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ALU_WB: ctrl.reg_write = 1'b1;
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_BR;
        ctrl.pc_write  = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = PC_JMP;
        ctrl.reg_write = (opcode == OP_JAL);
        ctrl.link_sel  = (opcode == OP_JAL);
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the 16-bit MISC-V core: state register,
// next-state logic and retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [2:0]           opcode,
  input  logic                 zero,
  multicycle_ctrl_if.master    mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 link_sel,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [3:0]           state_o,
  output logic [CNT_W-1:0]     retired
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       retire;
  ctrl_t      ctrl;

  ctrl_out_decode u_dec (
    .state     (state),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem.mem_ready),
    .ctrl      (ctrl)
  );

  assign retire = instr_retires(state, mem.mem_ready);

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:     state_nxt = run ? S_FETCH : S_IDLE;
      S_FETCH:    state_nxt = mem.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_R)            state_nxt = S_EXEC_R;
        else if (opcode == OP_I)       state_nxt = S_EXEC_I;
        else if (opcode[2:1] == 2'b01) state_nxt = S_MEM_ADDR;
        else if (opcode[2:1] == 2'b10) state_nxt = S_BRANCH;
        else                           state_nxt = S_JUMP;
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_ALU_WB;
      S_MEM_ADDR: state_nxt = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt = mem.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_nxt = S_MEM_WR;
      default:    state_nxt = S_IDLE;
    endcase
    // Every final cycle, including a store's handshake cycle, samples run here.
    if (retire) state_nxt = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + 1'b1;
  end

  assign mem.mem_req = ctrl.mem_req;
  assign mem.mem_we  = ctrl.mem_we;
  assign mem.iord    = ctrl.iord;
  assign ir_write    = ctrl.ir_write;
  assign pc_write    = ctrl.pc_write;
  assign pc_src      = ctrl.pc_src;
  assign reg_write   = ctrl.reg_write;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign link_sel    = ctrl.link_sel;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_op      = ctrl.alu_op;
  assign state_o     = state;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle main control FSM for the 16-bit MISC-V core. It sequences the shared datapath, which consists of the PC, IR, register file, ALU and a single memory port, over several cycles per instruction. It decodes the IR opcode field (instruction[2:0]), which is the same field the immediate generator uses to choose its immediate format. It also drives the ALU source/immediate muxes and handshakes with memory, and it counts retired instructions.

Parameters:
CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- run  in  1  1 = fetch new instructions; sampled at IDLE and at each instruction retire.
- opcode  in  3  IR[2:0]. Valid from DECODE onward, since the IR is written only in FETCH.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (valid only with mem_req).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  load PC.
- pc_src  out  2  PC source: 00 = ALU result (PC+2), 01 = ALUOut (branch target), 10 = jump target.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- link_sel  out  1  write-back data = PC (jal link).
- alu_src_a  out  1  ALU input A: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU input B: 00 = rt, 01 = constant 2, 10 = immediate.
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = function field.
- state_o  out  4  current state encoding (debug).
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Opcode map:
  - 000 R-type
  - 001 I-type
  - 010 load
  - 011 store
  - 100 beq
  - 101 bne
  - 110 j
  - 111 jal
- Reset (rst_n = 0, asynchronous): state = IDLE, retired = 0. Every output is 0 while in IDLE.
- Output timing: outputs are Moore (decoded from state) except for these Mealy terms:
  - FETCH: ir_write and pc_write follow mem_ready.
  - BRANCH: pc_write follows zero.
  - Any output not listed for a state is 0.
- Retire rule: an instruction retires in its final cycle. In that cycle retired increments (wrapping from all-ones to 0). Next state is FETCH if run = 1, else IDLE.
- States and transitions:
  - IDLE: run = 1 -> FETCH.
  - FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00. Stays in FETCH while mem_ready = 0. When mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 00, -> DECODE.
  - DECODE: alu_src_a = 0, alu_src_b = 10, alu_op = 00 (precomputes the branch target into ALUOut). Next state by opcode: 000 -> EXEC_R, 001 -> EXEC_I, 01x -> MEM_ADDR, 10x -> BRANCH, 11x -> JUMP.
  - EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> ALU_WB.
  - EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = 00 -> ALU_WB.
  - ALU_WB: reg_write = 1, mem_to_reg = 0; retire.
  - MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next: MEM_RD if opcode = 010, else MEM_WR.
  - MEM_RD: mem_req = 1, iord = 1. Holds until mem_ready, then -> MEM_WB.
  - MEM_WB: reg_write = 1, mem_to_reg = 1; retire.
  - MEM_WR: mem_req = 1, mem_we = 1, iord = 1. Holds until mem_ready; retires in the mem_ready cycle.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01. pc_write = zero for beq, ~zero for bne. Retire.
  - JUMP: pc_write = 1, pc_src = 10. For jal (111) only, also reg_write = 1 and link_sel = 1. Retire.
- Latency with zero-wait memory:
  - R/I: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch/jump: 3 cycles
  - Each wait cycle adds 1.
- Boundaries:
  - mem_ready is ignored in states where mem_req = 0.
  - mem_ready may be high in the first cycle of mem_req (zero-wait memory).
  - mem_req stays high and constant while waiting.
  - Deasserting run mid-instruction completes the instruction, then goes to IDLE.
  - Reset mid-wait drops mem_req immediately (asynchronously).
  - Unreachable state encodings -> IDLE.

Decomposition:
- Shared header misc_v_ctrl_defs.vh holds:
  - opcode constants
  - 4-bit state encoding: IDLE = 0, FETCH = 1, DECODE = 2, EXEC_R = 3, EXEC_I = 4, ALU_WB = 5, MEM_ADDR = 6, MEM_RD = 7, MEM_WB = 8, MEM_WR = 9, BRANCH = 10, JUMP = 11
  - alu_op, alu_src_b and pc_src codes
- One combinational sub-module, ctrl_out_decode, maps (state, opcode, zero, mem_ready) to the control outputs. The FSM register, next-state logic and counter stay in the top level.

Test Plan:
- Reset, then run = 1, R-type (opcode 000), mem_ready held 1 -> states 1, 2, 3, 5, 1. reg_write high exactly 1 cycle. retired = 1 after 4 cycles.
- Load (010) with mem_ready low for 2 cycles in MEM_RD -> mem_req and iord held high for 3 cycles. mem_to_reg = 1 in MEM_WB. Total 7 cycles.
- beq (100): zero = 1 -> pc_write = 1, pc_src = 01. Repeat with zero = 0 -> pc_write = 0. bne (101) inverts both cases.
- jal (111) -> JUMP cycle has pc_write = 1, pc_src = 10, reg_write = 1, link_sel = 1. j (110) has reg_write = 0.
- run dropped during EXEC_I -> instruction completes, then state = IDLE with all outputs 0. rst_n pulsed low mid-FETCH wait -> mem_req = 0 the same cycle, retired = 0.
- Preload retired = 0xFFFF (via 65535 instructions) and retire one more -> retired = 0x0000.
